data_mem_responder: RTL

- Memory-side responder for the CPU data port: services the stage-3 load/store requests the core issues on MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en and MEM_wr_en, and returns MEM_data in the same cycle.
- Holds byte-addressable word storage and a one-entry posted write buffer with store-to-load forwarding.
- Runs a post-reset clearing sequence and reports misaligned or out-of-range accesses.
- Instantiated beside the core in the SoC top level; mem_ready gates core reset release.

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-port memory responder: word array with post-reset clear, one-entry posted
// write buffer with byte-level store-to-load forwarding, sticky access-error flags.
//   state   | meaning
//   S_CLEAR | zeroing the array one word per cycle, requests ignored
//   S_RUN   | servicing loads and stores
module data_mem_responder #(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      MEM_addr,
  input  logic [31:0]      MEM_WR_out,
  input  logic [2:0]       MEM_type,
  input  logic             MEM_rd_en,
  input  logic             MEM_wr_en,
  output logic [31:0]      MEM_data,
  output logic             mem_ready,
  output logic             err_misalign,
  output logic             err_range,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             buf_valid;
  logic [IDX_W-1:0] buf_idx;
  logic [3:0]       buf_mask;
  logic [31:0]      buf_data;

  logic [1:0]       size;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             out_range;
  logic             misalign;
  logic             run;
  logic             req;
  logic             store_ok;
  logic             load_ok;
  logic [3:0]       size_mask;
  logic [31:0]      merged;
  logic [31:0]      shifted;
  logic             unused_type_sign;

  assign unused_type_sign = MEM_type[2];

  assign size      = MEM_type[1:0];
  assign lane      = MEM_addr[1:0];
  assign idx       = MEM_addr[IDX_W+1:2];
  assign out_range = |MEM_addr[31:IDX_W+2];
  assign misalign  = (size == 2'b11) ||
                     (size == 2'b01 && MEM_addr[0]) ||
                     (size == 2'b10 && lane != 2'b00);
  assign run       = (state == S_RUN);
  assign req       = MEM_rd_en || MEM_wr_en;
  assign store_ok  = run && MEM_wr_en && !misalign && !out_range;
  assign load_ok   = run && MEM_rd_en && !MEM_wr_en && !misalign && !out_range;
  assign mem_ready = run;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= S_CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  always_comb begin
    size_mask = 4'b1111;
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Pending buffered bytes override the array so a store is visible the next cycle.
  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (buf_valid && buf_idx == idx && buf_mask[b])
        merged[8*b +: 8] = buf_data[8*b +: 8];
    end
    shifted  = merged >> {lane, 3'b000};
    MEM_data = 32'h0;
    if (load_ok) begin
      case (size)
        2'b00:   MEM_data = shifted & 32'h0000_00FF;
        2'b01:   MEM_data = shifted & 32'h0000_FFFF;
        default: MEM_data = shifted;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      clr_idx      <= '0;
      buf_valid    <= 1'b0;
      buf_idx      <= '0;
      buf_mask     <= 4'b0000;
      buf_data     <= 32'h0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      load_count   <= '0;
      store_count  <= '0;
    end else begin
      if (!run) clr_idx <= clr_idx + 1'b1;
      if (store_ok) begin
        buf_valid <= 1'b1;
        buf_idx   <= idx;
        buf_mask  <= size_mask << lane;
        buf_data  <= MEM_WR_out << {lane, 3'b000};
      end else begin
        buf_valid <= 1'b0;
      end
      if (run && req && (misalign || (MEM_rd_en && MEM_wr_en))) err_misalign <= 1'b1;
      if (run && req && out_range) err_range <= 1'b1;
      if (load_ok && load_count != '1)   load_count  <= load_count + 1'b1;
      if (store_ok && store_count != '1) store_count <= store_count + 1'b1;
    end
  end

  // Array has no reset; the CLEAR walk provides its defined initial contents.
  always_ff @(posedge CLK) begin
    if (!run) begin
      mem[clr_idx] <= 32'h0;
    end else if (buf_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_mask[b]) mem[buf_idx][8*b +: 8] <= buf_data[8*b +: 8];
      end
    end
  end

endmodule
